dec_addkey_invmix: RTL and testbench

Decryption round stage sitting directly downstream of dec_subbytes in the AES-128 inverse cipher datapath.
- Takes the 128-bit InvSubBytes result plus the round key over a valid/ready handshake.
- Performs AddRoundKey, then InvMixColumns column-serially, except on the final round, where only AddRoundKey is applied.
- Result is held in an output register until the next round stage (InvShiftRows) or the block output accepts it.

---
 rtl/dec_aes_pkg.sv | 50 +++++
 rtl/dec_invmixcol_col.sv | 21 ++
 rtl/dec_addkey_invmix.sv | 88 ++++++++
 tb/tb_dec_addkey_invmix.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dec_aes_pkg.sv
// Shared AES inverse-cipher constants, GF(2^8) helpers and stage FSM encoding.
package dec_aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;
    localparam int unsigned NB      = 4;
    localparam int unsigned STATE_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] a);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(a)));
        return x8 ^ a;
    endfunction

    function automatic logic [7:0] gmulB(input logic [7:0] a);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(a);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ a;
    endfunction

    function automatic logic [7:0] gmulD(input logic [7:0] a);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(a));
        x8 = xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic logic [7:0] gmulE(input logic [7:0] a);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/dec_invmixcol_col.sv
// Combinational InvMixColumns for one 32-bit column, row 0 in the top byte.
module dec_invmixcol_col
    import dec_aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = din[31:24];
    assign a1 = din[23:16];
    assign a2 = din[15:8];
    assign a3 = din[7:0];

    assign dout[31:24] = gmulE(a0) ^ gmulB(a1) ^ gmulD(a2) ^ gmul9(a3);
    assign dout[23:16] = gmul9(a0) ^ gmulE(a1) ^ gmulB(a2) ^ gmulD(a3);
    assign dout[15:8]  = gmulD(a0) ^ gmul9(a1) ^ gmulE(a2) ^ gmulB(a3);
    assign dout[7:0]   = gmulB(a0) ^ gmulD(a1) ^ gmul9(a2) ^ gmulE(a3);

endmodule

// File: rtl/dec_addkey_invmix.sv
// AES-128 decryption stage: AddRoundKey then column-serial InvMixColumns (skipped on last round).
module dec_addkey_invmix
    import dec_aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [STATE_W-1:0] s_data,
    input  logic [STATE_W-1:0] s_key,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [STATE_W-1:0] m_data
);

    if (!(COLS_PER_CYCLE inside {1, 2, 4})) begin : g_bad_cols
        $error("dec_addkey_invmix: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_BASE = 2'(NB - COLS_PER_CYCLE);

    state_t             state_q;
    logic [1:0]         col_cnt_q;
    logic [STATE_W-1:0] work_q;
    logic [STATE_W-1:0] mixed;

    logic [1:0]  idx     [COLS_PER_CYCLE];
    logic [31:0] col_in  [COLS_PER_CYCLE];
    logic [31:0] col_out [COLS_PER_CYCLE];

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
        assign idx[i]    = col_cnt_q + 2'(i);
        assign col_in[i] = work_q[127 - 32 * int'(idx[i]) -: 32];

        dec_invmixcol_col u_col (
            .din  (col_in[i]),
            .dout (col_out[i])
        );
    end

    // Only the columns selected this cycle are replaced; the rest pass through.
    always_comb begin
        mixed = work_q;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            mixed[127 - 32 * int'(idx[i]) -: 32] = col_out[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_cnt_q <= 2'd0;
            work_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        work_q    <= s_data ^ s_key;
                        col_cnt_q <= 2'd0;
                        state_q   <= s_last ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    work_q    <= mixed;
                    col_cnt_q <= col_cnt_q + COL_STEP;
                    if (col_cnt_q == LAST_BASE) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready = (state_q == IDLE);
    assign m_valid = (state_q == DONE);
    assign m_data  = work_q;

endmodule

// File: tb/tb_dec_addkey_invmix.sv
// Directed bench for dec_addkey_invmix at COLS_PER_CYCLE = 1, 2 and 4.
module tb_dec_addkey_invmix;

    logic         clk = 1'b0;
    logic         rst;
    logic         v1, v2, v4;
    logic         r1, r2, r4;
    logic         mv1, mv2, mv4;
    logic [127:0] md1, md2, md4;
    logic [127:0] s_data, s_key;
    logic         s_last;
    logic         m_ready;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] KEY_A = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [127:0] RES_A = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] DAT_L = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_L = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RES_L = 128'h00102030405060708090a0b0c0d0e0f0;

    always #5 clk = ~clk;

    dec_addkey_invmix #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .s_valid(v1), .s_ready(r1), .s_data(s_data), .s_key(s_key),
        .s_last(s_last), .m_valid(mv1), .m_ready(m_ready), .m_data(md1)
    );
    dec_addkey_invmix #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .s_valid(v2), .s_ready(r2), .s_data(s_data), .s_key(s_key),
        .s_last(s_last), .m_valid(mv2), .m_ready(m_ready), .m_data(md2)
    );
    dec_addkey_invmix #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .s_valid(v4), .s_ready(r4), .s_data(s_data), .s_key(s_key),
        .s_last(s_last), .m_valid(mv4), .m_ready(m_ready), .m_data(md4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; v1 = 1'b0; v2 = 1'b0; v4 = 1'b0;
        s_data = '0; s_key = '0; s_last = 1'b0; m_ready = 1'b1;

        // Reset
        tick(); tick();
        rst = 1'b0;
        chk("rst_s_ready", 128'(r1), 128'd1);
        chk("rst_m_valid", 128'(mv1), 128'd0);
        chk("rst_m_data", md1, 128'd0);
        chk("rst_s_ready4", 128'(r4), 128'd1);

        // Non-last round, latency 5
        s_data = '0; s_key = KEY_A; s_last = 1'b0; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        chk("nl_busy_s_ready", 128'(r1), 128'd0);
        for (int k = 1; k <= 4; k++) begin
            chk("nl_no_valid_early", 128'(mv1), 128'd0);
            tick();
        end
        chk("nl_m_valid", 128'(mv1), 128'd1);
        chk("nl_m_data", md1, RES_A);
        tick();
        chk("nl_handoff_m_valid", 128'(mv1), 128'd0);
        chk("nl_handoff_s_ready", 128'(r1), 128'd1);

        // Last round, latency 1
        s_data = DAT_L; s_key = KEY_L; s_last = 1'b1; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        chk("last_m_valid", 128'(mv1), 128'd1);
        chk("last_m_data", md1, RES_L);
        tick();
        chk("last_idle", 128'(r1), 128'd1);

        // Backpressure, with a competing block offered during DONE
        s_data = '0; s_key = KEY_A; s_last = 1'b0; v1 = 1'b1; m_ready = 1'b0;
        tick();
        s_data = DAT_L; s_key = KEY_L; s_last = 1'b1;
        repeat (4) tick();
        for (int k = 0; k < 10; k++) begin
            chk("bp_m_valid", 128'(mv1), 128'd1);
            chk("bp_m_data", md1, RES_A);
            chk("bp_s_ready", 128'(r1), 128'd0);
            tick();
        end
        m_ready = 1'b1;
        tick();
        // Handoff edge must not also accept the waiting block.
        chk("bp_after_s_ready", 128'(r1), 128'd1);
        chk("bp_after_m_valid", 128'(mv1), 128'd0);
        chk("bp_after_m_data", md1, RES_A);
        tick();
        v1 = 1'b0;
        chk("bp_next_m_valid", 128'(mv1), 128'd1);
        chk("bp_next_m_data", md1, RES_L);
        tick();

        // Reset during the second BUSY cycle
        s_data = '0; s_key = KEY_A; s_last = 1'b0; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_s_ready", 128'(r1), 128'd1);
        chk("mid_rst_m_data", md1, 128'd0);
        for (int k = 0; k < 6; k++) begin
            chk("mid_rst_no_valid", 128'(mv1), 128'd0);
            tick();
        end
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        repeat (4) tick();
        chk("mid_rst_after_valid", 128'(mv1), 128'd1);
        chk("mid_rst_after_data", md1, RES_A);
        tick();

        // COLS_PER_CYCLE = 4 and 2
        s_data = '0; s_key = KEY_A; s_last = 1'b0; v2 = 1'b1; v4 = 1'b1;
        tick();
        v2 = 1'b0; v4 = 1'b0;
        chk("c4_busy_valid", 128'(mv4), 128'd0);
        chk("c2_busy_valid", 128'(mv2), 128'd0);
        tick();
        chk("c4_m_valid", 128'(mv4), 128'd1);
        chk("c4_m_data", md4, RES_A);
        chk("c2_still_busy", 128'(mv2), 128'd0);
        tick();
        chk("c2_m_valid", 128'(mv2), 128'd1);
        chk("c2_m_data", md2, RES_A);
        chk("c4_handed_off", 128'(r4), 128'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
